// File: rtl/sys_arr_if.sv
// rtl/sys_arr_if.sv - edge operand and cycle-count bundle for the sys_arr systolic array
interface sys_arr_if;
    logic [31:0] l11, l21, l31, l41;
    logic [31:0] u11, u12, u13, u14;
    logic [3:0]  count;

    modport master (
        output l11, l21, l31, l41,
        output u11, u12, u13, u14,
        input  count
    );

    modport slave (
        input  l11, l21, l31, l41,
        input  u11, u12, u13, u14,
        output count
    );
endinterface

// File: rtl/sys_arr.sv
// rtl/sys_arr.sv - 4x4 output-stationary FP32 multiply-accumulate systolic array
module sys_arr (
    input  logic     clk,
    input  logic     rst,
    sys_arr_if.slave bus
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int k = 26; k >= 0; k--) begin
            if (v[k]) found = 1'b1;
            else if (!found) n = n + 5'd1;
        end
        return n;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic              s, g, st;
        logic [47:0]       p;
        logic [23:0]       m;
        logic [24:0]       mr;
        logic signed [9:0] e;
        if (&x[30:23] || &y[30:23]) return QNAN;
        // Denormal operands flush to zero, and any zero operand yields +0.
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 32'h0;
        s = x[31] ^ y[31];
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        mr = {1'b0, m} + {24'd0, g & (st | m[0])};
        if (mr[24]) begin
            m = mr[24:1];
            e = e + 10'sd1;
        end else begin
            m = mr[23:0];
        end
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 10'sd0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic              g, st, lost;
        logic [31:0]       a, b;
        logic [7:0]        d;
        logic [4:0]        sh, lz;
        logic [26:0]       ma, mb, res;
        logic [27:0]       sum;
        logic [23:0]       m;
        logic [24:0]       mr;
        logic signed [9:0] e;
        if ((&x[30:23] && |x[22:0]) || (&y[30:23] && |y[22:0])) return QNAN;
        // Infinities from multiplier overflow must survive accumulation.
        if (&x[30:23] && &y[30:23] && (x[31] != y[31])) return QNAN;
        if (&x[30:23]) return x;
        if (&y[30:23]) return y;
        if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'd0) return y;
        if (y[30:23] == 8'd0) return x;
        if (y[30:0] > x[30:0]) begin
            a = y;
            b = x;
        end else begin
            a = x;
            b = y;
        end
        d    = a[30:23] - b[30:23];
        sh   = (d > 8'd27) ? 5'd27 : d[4:0];
        ma   = {1'b1, a[22:0], 3'b000};
        mb   = {1'b1, b[22:0], 3'b000};
        lost = |(mb & ((27'd1 << sh) - 27'd1));
        mb   = (mb >> sh) | {26'd0, lost};
        sum  = (a[31] == b[31]) ? ({1'b0, ma} + {1'b0, mb}) : ({1'b0, ma} - {1'b0, mb});
        if (sum == 28'd0) return 32'h0;
        e = $signed({2'b00, a[30:23]});
        if (sum[27]) begin
            res = sum[27:1] | {26'd0, sum[0]};
            e   = e + 10'sd1;
        end else begin
            lz  = lzc27(sum[26:0]);
            res = sum[26:0] << lz;
            e   = e - $signed({5'd0, lz});
        end
        m  = res[26:3];
        g  = res[2];
        st = |res[1:0];
        mr = {1'b0, m} + {24'd0, g & (st | m[0])};
        if (mr[24]) begin
            m = mr[24:1];
            e = e + 10'sd1;
        end else begin
            m = mr[23:0];
        end
        if (e >= 10'sd255) return {a[31], 8'hFF, 23'd0};
        if (e <= 10'sd0) return {a[31], 31'd0};
        return {a[31], e[7:0], m[22:0]};
    endfunction

    logic [31:0] l_edge [4];
    logic [31:0] u_edge [4];
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  count;

    assign l_edge[0] = bus.l11;
    assign l_edge[1] = bus.l21;
    assign l_edge[2] = bus.l31;
    assign l_edge[3] = bus.l41;
    assign u_edge[0] = bus.u11;
    assign u_edge[1] = bus.u12;
    assign u_edge[2] = bus.u13;
    assign u_edge[3] = bus.u14;

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            logic [31:0] left, top, acc_q, acc_d;

            if (j == 0) begin : g_lsrc
                assign left = l_edge[i];
            end else begin : g_lsrc
                assign left = g_row[i].g_col[j-1].g_a.a_q;
            end

            if (i == 0) begin : g_tsrc
                assign top = u_edge[j];
            end else begin : g_tsrc
                assign top = g_row[i-1].g_col[j].g_b.b_q;
            end

            always_comb begin
                acc_d = fp_add(acc_q, fp_mul(left, top));
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) acc_q <= '0;
                else      acc_q <= acc_d;
            end

            // The last column/row pipeline registers would feed nothing, so they are not built.
            if (j < 3) begin : g_a
                logic [31:0] a_q, a_d;
                always_comb a_d = left;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) a_q <= '0;
                    else      a_q <= a_d;
                end
            end

            if (i < 3) begin : g_b
                logic [31:0] b_q, b_d;
                always_comb b_d = top;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) b_q <= '0;
                    else      b_q <= b_d;
                end
            end
        end
    end

    always_comb begin
        cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign count     = cnt_q;
    assign bus.count = count;

    logic [31:0] r11, r12, r13, r14, r21, r22, r23, r24;
    logic [31:0] r31, r32, r33, r34, r41, r42, r43, r44;
    assign r11 = g_row[0].g_col[0].acc_q;
    assign r12 = g_row[0].g_col[1].acc_q;
    assign r13 = g_row[0].g_col[2].acc_q;
    assign r14 = g_row[0].g_col[3].acc_q;
    assign r21 = g_row[1].g_col[0].acc_q;
    assign r22 = g_row[1].g_col[1].acc_q;
    assign r23 = g_row[1].g_col[2].acc_q;
    assign r24 = g_row[1].g_col[3].acc_q;
    assign r31 = g_row[2].g_col[0].acc_q;
    assign r32 = g_row[2].g_col[1].acc_q;
    assign r33 = g_row[2].g_col[2].acc_q;
    assign r34 = g_row[2].g_col[3].acc_q;
    assign r41 = g_row[3].g_col[0].acc_q;
    assign r42 = g_row[3].g_col[1].acc_q;
    assign r43 = g_row[3].g_col[2].acc_q;
    assign r44 = g_row[3].g_col[3].acc_q;
endmodule

// File: tb/tb_sys_arr.sv
// tb/tb_sys_arr.sv - directed-vector bench for the sys_arr systolic array
module tb_sys_arr;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic [31:0] lv    [4];
    logic [31:0] uv    [4];
    logic [31:0] ma    [4][4];
    logic [31:0] mb    [4][4];
    logic [31:0] ex    [4][4];
    logic [31:0] r_obs [4][4];
    logic [31:0] fint  [17];

    sys_arr_if bus ();
    sys_arr dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign r_obs[0][0] = dut.r11;
    assign r_obs[0][1] = dut.r12;
    assign r_obs[0][2] = dut.r13;
    assign r_obs[0][3] = dut.r14;
    assign r_obs[1][0] = dut.r21;
    assign r_obs[1][1] = dut.r22;
    assign r_obs[1][2] = dut.r23;
    assign r_obs[1][3] = dut.r24;
    assign r_obs[2][0] = dut.r31;
    assign r_obs[2][1] = dut.r32;
    assign r_obs[2][2] = dut.r33;
    assign r_obs[2][3] = dut.r34;
    assign r_obs[3][0] = dut.r41;
    assign r_obs[3][1] = dut.r42;
    assign r_obs[3][2] = dut.r43;
    assign r_obs[3][3] = dut.r44;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    task automatic apply();
        bus.l11 = lv[0];
        bus.l21 = lv[1];
        bus.l31 = lv[2];
        bus.l41 = lv[3];
        bus.u11 = uv[0];
        bus.u12 = uv[1];
        bus.u13 = uv[2];
        bus.u14 = uv[3];
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            lv[k] = v;
            uv[k] = v;
        end
        apply();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_all(32'h0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic fill_ex(input logic [31:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                ex[i][j] = v;
    endtask

    task automatic check_arr(input string tag);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s r%0d%0d", tag, i + 1, j + 1), r_obs[i][j], ex[i][j]);
    endtask

    task automatic feed();
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < 4; i++) begin
                lv[i] = 32'h0;
                uv[i] = 32'h0;
                if (c - i >= 0 && c - i < 4) begin
                    lv[i] = ma[i][c - i];
                    uv[i] = mb[c - i][i];
                end
            end
            apply();
            tick();
        end
        set_all(32'h0);
        repeat (5) tick();
    endtask

    task automatic mac11(input logic [31:0] l, input logic [31:0] u);
        set_all(32'h0);
        lv[0] = l;
        uv[0] = u;
        apply();
        tick();
        set_all(32'h0);
    endtask

    task automatic fp_case(input string tag, input logic [31:0] l, input logic [31:0] want);
        do_reset();
        mac11(l, 32'h3F800000);
        repeat (3) tick();
        chk(tag, r_obs[0][0], want);
    endtask

    initial begin
        fint = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000,
                 32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000, 32'h41600000,
                 32'h41700000, 32'h41800000};

        // Unskewed ones for three edges, then asynchronous reset mid-cycle.
        do_reset();
        set_all(32'h3F800000);
        repeat (3) tick();
        chk("run r11", r_obs[0][0], 32'h40400000);
        chk("run r22", r_obs[1][1], 32'h40000000);
        chk("run count", {28'd0, bus.count}, 32'd3);
        #3 rst = 1'b0;
        #1;
        fill_ex(32'h0);
        check_arr("async_rst");
        chk("async_rst count", {28'd0, bus.count}, 32'd0);

        // Unskewed single pulse gives the identity.
        do_reset();
        repeat (3) tick();
        set_all(32'h3F800000);
        tick();
        set_all(32'h0);
        repeat (6) tick();
        fill_ex(32'h0);
        for (int k = 0; k < 4; k++) ex[k][k] = 32'h3F800000;
        check_arr("pulse");

        // Skewed all-ones product.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 32'h3F800000;
                mb[i][j] = 32'h3F800000;
            end
        feed();
        fill_ex(32'h40800000);
        check_arr("ones");

        // A = 1..16 row-major, B = identity.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = fint[4 * i + j + 1];
                mb[i][j] = (i == j) ? 32'h3F800000 : 32'h0;
                ex[i][j] = fint[4 * i + j + 1];
            end
        feed();
        check_arr("a_times_i");

        // Counter ramps to 15 and saturates.
        do_reset();
        for (int n = 1; n <= 15; n++) begin
            tick();
            chk($sformatf("count ramp %0d", n), {28'd0, bus.count}, n);
        end
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("count hold", {28'd0, bus.count}, 32'd15);
        end

        // FP corner cases on PE(1,1).
        fp_case("fp denorm", 32'h00000001, 32'h00000000);
        do_reset();
        mac11(32'h7F000000, 32'h40000000);
        repeat (3) tick();
        chk("fp overflow", r_obs[0][0], 32'h7F800000);
        fp_case("fp nan", 32'h7FC00000, 32'h7FC00000);
        fp_case("fp mul rne", 32'h3FC00000, 32'h3FC00000);
        do_reset();
        mac11(32'h3FC00000, 32'h3F800001);
        tick();
        chk("fp mul tie even", r_obs[0][0], 32'h3FC00002);

        do_reset();
        mac11(32'h3F800000, 32'h3F800000);
        chk("fp cancel step1", r_obs[0][0], 32'h3F800000);
        mac11(32'hBF800000, 32'h3F800000);
        repeat (2) tick();
        chk("fp cancel", r_obs[0][0], 32'h00000000);

        do_reset();
        mac11(32'h3F800000, 32'h3F800000);
        mac11(32'h33800000, 32'h3F800000);
        tick();
        chk("fp add tie", r_obs[0][0], 32'h3F800000);

        do_reset();
        mac11(32'h3F800000, 32'h3F800000);
        mac11(32'h33800001, 32'h3F800000);
        tick();
        chk("fp add up", r_obs[0][0], 32'h3F800001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sys_arr.md
# sys_arr

4×4 output-stationary systolic array of IEEE-754 single-precision multiply-accumulate processing elements (PEs). It computes C = A·B for 4×4 FP32 matrices streamed in skewed form: rows of A from the left edge, columns of B from the top edge. Each PE accumulates one element of C in place and passes its operands to its right and lower neighbours. It is the matrix-multiply datapath core; results are read from the internal accumulators `r11`..`r44`, and a cycle counter is exported for sequencing.

## Interface
- No parameters. Array size is fixed at 4×4 and data width at 32 bits (FP32).
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-low; clears all state.
- `l11`, `l21`, `l31`, `l41`  in  32  — left-edge FP32 operands (A) for rows 1–4; sampled directly by PE(i,1).
- `u11`, `u12`, `u13`, `u14`  in  32  — top-edge FP32 operands (B) for columns 1–4; sampled directly by PE(1,j).
- `count`  out  4  — cycles elapsed since reset release; saturates at 15.
- Internal observable registers, which must keep exactly these names: `r11`..`r44` (32-bit accumulator of PE(i,j)) and `count`.

## Operation
- PE(i,j) holds three registers:
  - `r_ij`, the accumulator;
  - `a_ij`, the horizontal pipeline register, driving PE(i,j+1);
  - `b_ij`, the vertical pipeline register, driving PE(i+1,j).
- PE(i,j) operand sources:
  - Left operand: `l_i1` when j=1, else `a_i(j-1)`.
  - Top operand: `u_1j` when i=1, else `b_(i-1)j`.
- Every cycle, each PE does:
  - `r_ij <= r_ij + left*top`, as an FP32 multiply then FP32 add, combinational within one cycle;
  - `a_ij <= left`;
  - `b_ij <= top`.
- There is no enable. The array accumulates every cycle, so idle inputs must be driven to 0x00000000.
- FP arithmetic rules:
  - Rounding is round-to-nearest-even.
  - Denormal inputs and denormal results are flushed to signed zero.
  - A product with either operand zero is exactly +0.
  - Overflow gives ±Inf (0x7F800000 / 0xFF800000).
  - Any operand with exponent 255 gives 0x7FC00000.
  - x + (−x) gives +0.
- Feeding convention for C = A·B:
  - `l_i1` receives A(i,k) at cycle k+(i−1), for k = 0..3.
  - `u_1j` receives B(k,j) at cycle k+(j−1).
  - At all other cycles both inputs are 0.
  - A(i,k) and B(k,j) then meet in PE(i,j) in the same cycle.
- `count`: 0 while reset is asserted; +1 per rising edge after release; holds at 15.

## Timing
- Reset (`rst`=0) asynchronously sets all 16 `r_ij`, all `a_ij`/`b_ij`, and `count` to 0. Outputs reflect this immediately, without waiting for a clock edge.
- Reset mid-computation discards all partial sums and in-flight operands. On release, computation restarts from zero state.
- Operand hop latency: 1 cycle per PE.
  - A value on `l_i1` is used by PE(i,j) j−1 cycles after it is used by PE(i,1).
  - A value on `u_1j` is used by PE(i,j) i−1 cycles after it is used by PE(1,j).
- Full skewed 4×4 product: the last nonzero input is applied at cycle 6. All of C is final after the edge at cycle 9, i.e. 10 cycles after the first input.
- Once inputs return to zero, accumulators hold their value indefinitely.

## Test plan
- Reset: assert `rst`=0 mid-run with nonzero inputs -> all `r_ij`=0x00000000 and `count`=0 immediately, without a clock edge.
- Unskewed single pulse:
  - Stimulus: all 8 inputs 0 for 3 cycles, then 0x3F800000 on all 8 for one cycle, then 0.
  - Required after ≥5 further cycles: `r_ii`=0x3F800000 and all off-diagonal `r_ij`=0x00000000 (identity).
- Skewed all-ones:
  - Stimulus: A=B=all 1.0, fed with the skew above over 7 cycles, then wait 5 cycles.
  - Required: all 16 `r_ij`=0x40800000 (4.0).
- General product:
  - Stimulus: A = [[1,2,3,4],…] and B = I, skewed.
  - Required: `r_ij` equals A(i,j) bit-exactly, e.g. `r12`=0x40000000.
- Counter: after release, `count` reads 1,2,…,15, then holds at 15 for ≥20 further cycles.
- FP edge cases:
  - 0x00000001 (denormal) × 1.0 -> accumulator stays 0.
  - 0x7F000000 × 0x40000000 -> 0x7F800000.
  - 0x7FC00000 × 1.0 -> 0x7FC00000.
  - 1.0×1.0 followed by (−1.0)×1.0 -> +0 (0x00000000).
